// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game controller.
// Holds state codes, default playfield size and winner codes.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_POINT = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/pong_frame_counter.sv
// Loadable 8-bit frame down-counter shared by the serve and point delays.
// done pulses on the enabled tick that finds the count at 1.
module pong_frame_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    input  logic       tick,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en && tick && count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign done = en && tick && (count == 8'd1);

endmodule

// File: rtl/pong_game_ctrl.sv
// Rally lifecycle controller: attract, serve, play, pause, point, game over.
// Detects misses on frame ticks and keeps saturating 4-bit scores.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_W     = SCREEN_W_DEF,
    parameter int SCREEN_H     = SCREEN_H_DEF,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_LEN   = 80,
    parameter int BALL_W       = 8,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic [9:0] ball_x,
    input  logic [8:0] ball_y,
    input  logic       ball_direction,
    input  logic [8:0] left_y,
    input  logic [8:0] right_y,
    output logic [2:0] state,
    output logic       ball_hold,
    output logic       play_en,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] winner
);

    if (SCREEN_W > 1024 || SCREEN_H > 512) begin : g_bad_geom
        $error("playfield exceeds coordinate port widths");
    end

    localparam logic [9:0]  BALL_W10  = 10'(BALL_W);
    localparam logic [9:0]  PLEN10    = 10'(PADDLE_LEN);
    localparam logic [10:0] BALL_W11  = 11'(BALL_W);
    localparam logic [10:0] LEFT_LIM  = 11'(PADDLE_W);
    localparam logic [10:0] RIGHT_LIM = 11'(SCREEN_W - PADDLE_W);
    localparam logic [3:0]  WIN4      = 4'(WIN_SCORE);
    localparam logic [7:0]  SERVE8    = 8'(SERVE_FRAMES);
    localparam logic [7:0]  POINT8    = 8'(POINT_FRAMES);

    function automatic logic y_clear(input logic [8:0] by,
                                     input logic [8:0] py);
        return ({1'b0, by} + BALL_W10 <= {1'b0, py}) ||
               ({1'b0, by} >= {1'b0, py} + PLEN10);
    endfunction

    state_t     st, st_n;
    logic       btn_q, press;
    logic       miss_l, miss_r;
    logic       hold_n, en_n, dir_n;
    logic [3:0] sl_n, sr_n;
    logic [1:0] win_n;
    logic       cnt_load, cnt_en, cnt_done;
    logic [7:0] cnt_val;

    assign press  = start_btn && !btn_q;
    assign miss_l = !ball_direction &&
                    ({1'b0, ball_x} <= LEFT_LIM) &&
                    y_clear(ball_y, left_y);
    assign miss_r = ball_direction &&
                    ({1'b0, ball_x} + BALL_W11 >= RIGHT_LIM) &&
                    y_clear(ball_y, right_y);
    assign state  = st;

    pong_frame_counter u_frames (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .tick     (frame_tick),
        .done     (cnt_done)
    );

    always_comb begin
        st_n     = st;
        dir_n    = serve_dir;
        sl_n     = score_l;
        sr_n     = score_r;
        win_n    = winner;
        cnt_load = 1'b0;
        cnt_val  = SERVE8;
        cnt_en   = 1'b0;
        case (st)
            ST_IDLE: if (press) begin
                sl_n     = 4'd0;
                sr_n     = 4'd0;
                dir_n    = 1'b1;
                cnt_load = 1'b1;
                st_n     = ST_SERVE;
            end
            ST_SERVE: begin
                cnt_en = 1'b1;
                if (cnt_done) st_n = ST_PLAY;
            end
            ST_PLAY: begin
                // left miss has priority, and any miss drops a same-cycle press
                if (frame_tick && miss_l) begin
                    sr_n     = sat_inc(score_r);
                    dir_n    = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = POINT8;
                    st_n     = ST_POINT;
                end else if (frame_tick && miss_r) begin
                    sl_n     = sat_inc(score_l);
                    dir_n    = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = POINT8;
                    st_n     = ST_POINT;
                end else if (press) begin
                    st_n = ST_PAUSE;
                end
            end
            ST_PAUSE: if (press) st_n = ST_PLAY;
            ST_POINT: begin
                cnt_en = 1'b1;
                if (cnt_done) begin
                    if (score_l == WIN4) begin
                        win_n = WIN_LEFT;
                        st_n  = ST_OVER;
                    end else if (score_r == WIN4) begin
                        win_n = WIN_RIGHT;
                        st_n  = ST_OVER;
                    end else begin
                        cnt_load = 1'b1;
                        st_n     = ST_SERVE;
                    end
                end
            end
            ST_OVER: if (press) begin
                win_n = WIN_NONE;
                st_n  = ST_IDLE;
            end
            default: st_n = ST_IDLE;
        endcase
        hold_n = (st_n == ST_IDLE) || (st_n == ST_SERVE) ||
                 (st_n == ST_OVER);
        en_n   = (st_n == ST_SERVE) || (st_n == ST_PLAY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= ST_IDLE;
            btn_q     <= 1'b0;
            ball_hold <= 1'b1;
            play_en   <= 1'b0;
            serve_dir <= 1'b1;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            winner    <= WIN_NONE;
        end else begin
            st        <= st_n;
            btn_q     <= start_btn;
            ball_hold <= hold_n;
            play_en   <= en_n;
            serve_dir <= dir_n;
            score_l   <= sl_n;
            score_r   <= sr_n;
            winner    <= win_n;
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed rally scenarios plus random play,
// all compared every cycle against a rule-level game model.
module tb_pong_game_ctrl;

    localparam int SF  = 60;
    localparam int PF  = 90;
    localparam int WIN = 7;

    logic       clk = 1'b0;
    logic       reset, frame_tick, start_btn, ball_direction;
    logic [9:0] ball_x;
    logic [8:0] ball_y, left_y, right_y;
    logic [2:0] state;
    logic       ball_hold, play_en, serve_dir;
    logic [3:0] score_l, score_r;
    logic [1:0] winner;

    int n_checks = 0;
    int n_pass   = 0;

    // model: game phase, frames still to wait, scores, winner, serve side
    int m_state, m_left, m_sl, m_sr, m_win, m_dir, m_prev;

    pong_game_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .start_btn      (start_btn),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .ball_direction (ball_direction),
        .left_y         (left_y),
        .right_y        (right_y),
        .state          (state),
        .ball_hold      (ball_hold),
        .play_en        (play_en),
        .serve_dir      (serve_dir),
        .score_l        (score_l),
        .score_r        (score_r),
        .winner         (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      name, act, exp, $time);
    endtask

    function automatic bit y_clear(input int by, input int py);
        return (by + 8 <= py) || (by >= py + 80);
    endfunction

    function automatic bit lmiss();
        return ball_direction == 1'b0 && int'(ball_x) <= 10 &&
               y_clear(int'(ball_y), int'(left_y));
    endfunction

    function automatic bit rmiss();
        return ball_direction == 1'b1 && int'(ball_x) + 8 >= 630 &&
               y_clear(int'(ball_y), int'(right_y));
    endfunction

    task automatic model_reset();
        m_state = 0; m_left = 0; m_sl = 0; m_sr = 0;
        m_win = 0; m_dir = 1; m_prev = 0;
    endtask

    task automatic model_edge();
        bit pr;
        if (reset) begin
            model_reset();
            return;
        end
        pr = start_btn && !m_prev;
        m_prev = start_btn;
        case (m_state)
            0: if (pr) begin
                m_sl = 0; m_sr = 0; m_dir = 1; m_left = SF; m_state = 1;
            end
            1: if (frame_tick) begin
                m_left--;
                if (m_left == 0) m_state = 2;
            end
            2: if (frame_tick && lmiss()) begin
                m_sr = (m_sr < 15) ? m_sr + 1 : 15;
                m_dir = 0; m_left = PF; m_state = 4;
            end else if (frame_tick && rmiss()) begin
                m_sl = (m_sl < 15) ? m_sl + 1 : 15;
                m_dir = 1; m_left = PF; m_state = 4;
            end else if (pr) m_state = 3;
            3: if (pr) m_state = 2;
            4: if (frame_tick) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_sl == WIN) begin m_win = 1; m_state = 5; end
                    else if (m_sr == WIN) begin m_win = 2; m_state = 5; end
                    else begin m_left = SF; m_state = 1; end
                end
            end
            default: if (pr) begin m_win = 0; m_state = 0; end
        endcase
    endtask

    task automatic compare_all();
        check("state", int'(state), m_state);
        check("ball_hold", int'(ball_hold),
              (m_state == 0 || m_state == 1 || m_state == 5) ? 1 : 0);
        check("play_en", int'(play_en),
              (m_state == 1 || m_state == 2) ? 1 : 0);
        check("serve_dir", int'(serve_dir), m_dir);
        check("score_l", int'(score_l), m_sl);
        check("score_r", int'(score_r), m_sr);
        check("winner", int'(winner), m_win);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic safe_geom();
        ball_x = 10'd300; ball_y = 9'd200; ball_direction = 1'b0;
        left_y = 9'd100; right_y = 9'd100;
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) step();
        frame_tick = 1'b0;
    endtask

    task automatic press();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        step();
    endtask

    task automatic tick_once();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic left_miss_geom();
        ball_x = 10'd5; ball_y = 9'd300; ball_direction = 1'b0;
        left_y = 9'd100;
    endtask

    task automatic right_miss_geom();
        ball_x = 10'd622; ball_y = 9'd300; ball_direction = 1'b1;
        right_y = 9'd100;
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; start_btn = 1'b0;
        safe_geom();
        model_reset();
        #3;
        check("rst_state", int'(state), 0);
        check("rst_hold", int'(ball_hold), 1);
        check("rst_play_en", int'(play_en), 0);
        check("rst_serve_dir", int'(serve_dir), 1);
        step();
        reset = 1'b0;
        step();

        // serve countdown
        start_btn = 1'b1;
        step();
        check("press_serve", int'(state), 1);
        start_btn = 1'b0;
        step();
        ticks(SF - 1);
        check("serve_59", int'(state), 1);
        ticks(1);
        check("serve_play", int'(state), 2);
        check("play_hold", int'(ball_hold), 0);
        check("play_scores", int'(score_l) + int'(score_r), 0);

        // left miss then point delay
        left_miss_geom();
        tick_once();
        check("lmiss_sr", int'(score_r), 1);
        check("lmiss_dir", int'(serve_dir), 0);
        check("lmiss_state", int'(state), 4);
        safe_geom();
        ticks(PF - 1);
        check("point_89", int'(state), 4);
        ticks(1);
        check("point_serve", int'(state), 1);
        ticks(SF);

        // hits and boundaries
        ball_x = 10'd5; ball_y = 9'd140; left_y = 9'd100;
        ball_direction = 1'b0;
        tick_once();
        ball_y = 9'd93;
        tick_once();
        ball_x = 10'd11; ball_y = 9'd300;
        tick_once();
        check("hit_state", int'(state), 2);
        check("hit_sr", int'(score_r), 1);
        ball_x = 10'd5; ball_y = 9'd180;
        tick_once();
        check("edge_miss", int'(state), 4);
        check("edge_sr", int'(score_r), 2);
        safe_geom();
        ticks(PF + SF);

        // pause
        start_btn = 1'b1;
        step();
        check("pause_state", int'(state), 3);
        check("pause_en", int'(play_en), 0);
        start_btn = 1'b0;
        step();
        left_miss_geom();
        ticks(10);
        check("pause_sr", int'(score_r), 2);
        safe_geom();
        press();
        check("resume", int'(state), 2);

        // press coinciding with a miss
        left_miss_geom();
        start_btn = 1'b1;
        tick_once();
        start_btn = 1'b0;
        check("miss_vs_press", int'(state), 4);
        safe_geom();
        ticks(PF + SF);

        // right misses to a left win
        for (int i = 0; i < WIN; i++) begin
            right_miss_geom();
            tick_once();
            safe_geom();
            ticks(PF);
            if (i < WIN - 1) ticks(SF);
        end
        check("over_state", int'(state), 5);
        check("over_winner", int'(winner), 1);
        check("over_sl", int'(score_l), 7);
        press();
        check("idle_state", int'(state), 0);
        check("idle_winner", int'(winner), 0);

        // reach 3/2 and reset inside POINT
        press();
        check("new_scores", int'(score_l) + int'(score_r), 0);
        ticks(SF);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) right_miss_geom();
            else left_miss_geom();
            tick_once();
            safe_geom();
            if (i < 4) ticks(PF + SF);
        end
        ticks(5);
        check("pt_state", int'(state), 4);
        check("pt_sl", int'(score_l), 3);
        check("pt_sr", int'(score_r), 2);
        #2;
        reset = 1'b1;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_hold", int'(ball_hold), 1);
        check("arst_en", int'(play_en), 0);
        check("arst_dir", int'(serve_dir), 1);
        check("arst_sl", int'(score_l), 0);
        check("arst_sr", int'(score_r), 0);
        check("arst_win", int'(winner), 0);
        step();
        reset = 1'b0;
        step();

        // random play
        for (int c = 0; c < 20000; c++) begin
            int sel;
            frame_tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) start_btn = ~start_btn;
            ball_direction = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 3);
            if (sel == 0) ball_x = 10'($urandom_range(0, 14));
            else if (sel == 1) ball_x = 10'($urandom_range(618, 639));
            else ball_x = 10'($urandom_range(15, 617));
            ball_y  = 9'($urandom_range(0, 471));
            left_y  = 9'($urandom_range(0, 400));
            right_y = 9'($urandom_range(0, 400));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-sequencing controller for the pong datapath. It owns the rally lifecycle: idle attract, serve countdown, live play, point award and game over. Each frame it watches the ball position and both paddle positions to detect misses. It keeps both scores and drives the hold/enable controls that freeze or release the ball and paddle movers.

## Interface
Parameters:
- SCREEN_W, 640, playfield width in pixels
- SCREEN_H, 480, playfield height in pixels
- PADDLE_W, 10, paddle width in pixels
- PADDLE_LEN, 80, paddle length in pixels
- BALL_W, 8, ball edge length in pixels
- WIN_SCORE, 7, points needed to win (1..15)
- SERVE_FRAMES, 60, frames ball is held before serve
- POINT_FRAMES, 90, frames of freeze after a point

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clk
- frame_tick  in  1  one-cycle pulse per video frame
- start_btn  in  1  debounced start/pause button, level
- ball_x  in  10  ball upper-left X
- ball_y  in  9  ball upper-left Y
- ball_direction  in  1  1 = moving right, 0 = moving left
- left_y  in  9  left paddle upper-left Y
- right_y  in  9  right paddle upper-left Y
- state  out  3  current FSM state code
- ball_hold  out  1  ball mover holds ball centred
- play_en  out  1  paddle and ball movers may advance
- serve_dir  out  1  direction of the next serve, 1 = right
- score_l, score_r  out  4  player scores
- winner  out  2  00 none, 01 left, 10 right

## Operation
- Start button is edge-detected internally: a rising edge in the registered sample gives one press.
- States: IDLE(0), SERVE(1), PLAY(2), PAUSE(3), POINT(4), OVER(5).
- IDLE: ball_hold=1, play_en=0. On press: clear scores, set serve_dir=1, load frame counter with SERVE_FRAMES, go to SERVE.
- SERVE: ball_hold=1, play_en=1 (paddles track). Counter decrements on frame_tick. When the tick finds counter==1, go to PLAY.
- PLAY: ball_hold=0, play_en=1. Miss checks run only on frame_tick.
  - Left miss: ball_direction=0, ball_x<=PADDLE_W, and (ball_y+BALL_W<=left_y or ball_y>=left_y+PADDLE_LEN).
  - Right miss: ball_direction=1, ball_x+BALL_W>=SCREEN_W-PADDLE_W, and the same Y test against right_y.
  - Left miss: score_r++ and serve_dir=0.
  - Right miss: score_l++ and serve_dir=1.
  - After a miss: load POINT_FRAMES and go to POINT.
  - If both misses are true on the same tick, the left miss wins.
  - A press in PLAY goes to PAUSE.
- PAUSE: play_en=0, ball_hold=0 (ball frozen in place). A press returns to PLAY. Ticks are ignored.
- POINT: play_en=0, ball_hold=0. Counter counts down as in SERVE. At expiry:
  - If either score equals WIN_SCORE: set winner and go to OVER.
  - Otherwise: load SERVE_FRAMES and go to SERVE.
- OVER: ball_hold=1, play_en=0, scores and winner held. A press goes to IDLE with winner cleared; scores are cleared on the next IDLE→SERVE.
- Arithmetic: scores are 4-bit unsigned and saturate at 15. Y sums use 10-bit intermediates, and X sums use 11-bit intermediates, so nothing wraps.

## Timing
- Reset values: state=IDLE, ball_hold=1, play_en=0, serve_dir=1, score_l=score_r=0, winner=00, counter=0, button sample=0.
- All outputs are registered and update the cycle after the deciding edge.
- A press in IDLE/PLAY/PAUSE/OVER acts in the cycle after the rising edge. A held button produces exactly one press.
- Serve delay: exactly SERVE_FRAMES frame_ticks from entering SERVE to entering PLAY. POINT delay is POINT_FRAMES ticks, counted the same way.
- Score increment and the move to POINT happen in the same cycle, one cycle after the deciding frame_tick.
- A press coinciding with a miss tick in PLAY: the miss wins and the press is dropped.
- A press in SERVE or POINT is ignored.
- Reset asserted mid-game returns all state to reset values immediately (asynchronously).

## Structure
- Shared package pong_pkg holds:
  - the state enum and its codes;
  - SCREEN_W/SCREEN_H defaults;
  - winner codes.
- Sub-module pong_frame_counter: a loadable down-counter of 8 bits that decrements on frame_tick and has a done flag. It is used for both the SERVE and POINT delays.

## Test plan
- Reset, then a press → state goes IDLE→SERVE; after 60 ticks PLAY with ball_hold=0 and scores 0/0.
- PLAY tick with ball_x=5, ball_direction=0, ball_y=300, left_y=100 → score_r=1, serve_dir=0, state POINT. After 90 ticks the state is SERVE.
- PLAY tick with ball_x=5, ball_direction=0, ball_y=140, left_y=100 (hit) → no score change, still PLAY.
- Force right misses until score_l=7 → after the POINT delay: OVER, winner=01. A press goes to IDLE with winner=00.
- A press in PLAY gives PAUSE with play_en=0; 10 ticks with miss geometry give no score; a second press returns to PLAY.
- Assert reset in POINT with score 3/2 → all outputs return to reset values in the same cycle.
